// File: rtl/display_arbiter.sv
// display_arbiter: round-robin arbiter that shares one display_signal engine
// among NUM_REQ debug requesters. The winner's word is latched, a start pulse
// is sent, and the requester is acked once the engine reports done again.
// Optional feature macro: DISPLAY_ARB_TIMEOUT_EN (abort a transfer after
// TIMEOUT cycles without done and raise a sticky timeout_err).
module display_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int width   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*width-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     busy,
    output logic [width-1:0]         display_signal_data,
    output logic                     display_signal_start,
    input  logic                     display_signal_done,
    output logic                     timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_BASE = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptrNext;
    logic [PTR_W-1:0]     r_win;
    logic [PTR_W-1:0]     w_winNext;
    logic [width-1:0]     r_data;
    logic [width-1:0]     w_dataNext;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grantNext;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ackNext;
    logic                 r_start;
    logic                 w_startNext;
    logic                 r_busy;
    logic                 w_busyNext;

    logic [PTR_W-1:0]     w_arbWin;
    logic [PTR_W-1:0]     w_scanIdx;
    logic                 w_arbFound;
    logic [width-1:0]     w_arbData;
    logic [PTR_W-1:0]     w_winWrap;
    logic                 w_timeoutHit;

    // Rotating priority scan: first set request at ptr, ptr+1, ... wrapping.
    always_comb begin
        w_arbWin   = '0;
        w_arbFound = 1'b0;
        w_scanIdx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scanIdx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_arbFound && req[w_scanIdx]) begin
                w_arbFound = 1'b1;
                w_arbWin   = w_scanIdx;
            end
        end
    end

    assign w_arbData = req_data[int'(w_arbWin)*width +: width];
    assign w_winWrap = (r_win == PTR_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;

`ifdef DISPLAY_ARB_TIMEOUT_EN
    // The limit is TIMEOUT-2 so that the abort ack lands exactly TIMEOUT
    // cycles after the start pulse (counter clears on the START cycle and
    // the ack itself is one registered cycle later).
    localparam int COUNT_W = $clog2(TIMEOUT+1);
    localparam logic [COUNT_W-1:0] COUNT_LIMIT = COUNT_W'(TIMEOUT-2);

    logic [COUNT_W-1:0] r_count;
    logic               r_timeoutErr;

    assign w_timeoutHit = (r_count == COUNT_LIMIT);

    // Wait-cycle counter and sticky abort flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_count <= '0;
            end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
                r_count <= r_count + 1'b1;
            end
            if (w_timeoutHit && ((r_state == S_WAIT_BUSY) ||
                                 (r_state == S_WAIT_DONE && !display_signal_done))) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeoutErr;
`else
    assign w_timeoutHit = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_winNext   = r_win;
        w_dataNext  = r_data;
        w_grantNext = '0;
        w_ackNext   = '0;
        w_startNext = 1'b0;
        w_busyNext  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_busyNext = 1'b0;
                // The ack cycle is not allowed to arbitrate, which leaves
                // one idle (busy low) cycle between back-to-back transfers.
                if ((r_ack == '0) && (req != '0) && display_signal_done) begin
                    w_winNext   = w_arbWin;
                    w_dataNext  = w_arbData;
                    w_grantNext = ONE_HOT_BASE << w_arbWin;
                    w_busyNext  = 1'b1;
                    w_stateNext = S_GRANT;
                end
            end
            S_GRANT: begin
                w_startNext = 1'b1;
                w_stateNext = S_START;
            end
            S_START: begin
                w_stateNext = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_timeoutHit) begin
                    w_ackNext   = ONE_HOT_BASE << r_win;
                    w_ptrNext   = w_winWrap;
                    w_stateNext = S_IDLE;
                end else if (!display_signal_done) begin
                    w_stateNext = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (display_signal_done || w_timeoutHit) begin
                    w_ackNext   = ONE_HOT_BASE << r_win;
                    w_ptrNext   = w_winWrap;
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; reset aborts without an ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_data  <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_win   <= w_winNext;
            r_data  <= w_dataNext;
            r_grant <= w_grantNext;
            r_ack   <= w_ackNext;
            r_start <= w_startNext;
            r_busy  <= w_busyNext;
        end
    end

    assign grant                = r_grant;
    assign ack                  = r_ack;
    assign busy                 = r_busy;
    assign display_signal_data  = r_data;
    assign display_signal_start = r_start;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: self-checking bench for display_arbiter (4 requesters,
// 16-bit words, TIMEOUT=8). Scenario tasks check inline; the randomized test
// predicts winners with a simple rotating-priority model.
module tb_display_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] reqData = '0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
    logic [15:0] displayData;
    logic        displayStart;
    logic        displayDone = 1'b1;
    logic        timeoutErr;

    int errors = 0;
    int checks = 0;
    int mPtr = 0;
    logic [15:0] words [4];

    display_arbiter #(
        .NUM_REQ(4),
        .width  (16),
        .TIMEOUT(8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .req                 (req),
        .req_data            (reqData),
        .grant               (grant),
        .ack                 (ack),
        .busy                (busy),
        .display_signal_data (displayData),
        .display_signal_start(displayStart),
        .display_signal_done (displayDone),
        .timeout_err         (timeoutErr)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Hard stop in case a scenario stalls in a way no bounded loop caught.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyReset();
        reset       = 1'b1;
        req         = '0;
        displayDone = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mPtr  = 0;
    endtask

    task automatic packWords();
        reqData = {words[3], words[2], words[1], words[0]};
    endtask

    task automatic waitGrant(output logic [3:0] g, output int lat);
        int n;
        n = 0;
        g = '0;
        while (g == '0 && n < 40) begin
            @(negedge clock);
            n++;
            g = grant;
        end
        lat = n;
    endtask

    task automatic finishTransfer(input int lowCycles, output logic startSeen,
                                  output logic [15:0] d, output logic [3:0] a,
                                  output int ackLat);
        int n;
        @(negedge clock);
        startSeen   = displayStart;
        d           = displayData;
        displayDone = 1'b0;
        repeat (lowCycles) @(negedge clock);
        displayDone = 1'b1;
        n = 0;
        a = '0;
        while (a == '0 && n < 40) begin
            @(negedge clock);
            n++;
            a = ack;
        end
        ackLat = n;
    endtask

    task automatic test_reset();
        logic [3:0] g;
        logic [3:0] a;
        logic [15:0] d;
        logic s;
        int lat;
        int al;
        reset = 1'b1;
        displayDone = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        packWords();
        repeat (2) @(negedge clock);
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (displayStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b want 0", displayStart); end
        checks++; if (displayData !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h want 0000", displayData); end
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b want 0", timeoutErr); end
        reset = 1'b0;
        req = 4'b0110;
        waitGrant(g, lat);
        checks++; if (g !== 4'b0010) begin errors++; $display("[TB] FAIL first_grant: got %b want 0010", g); end
        req = '0;
        finishTransfer(2, s, d, a, al);
        checks++; if (a !== 4'b0010) begin errors++; $display("[TB] FAIL first_ack: got %b want 0010", a); end
    endtask

    task automatic test_single();
        logic [3:0] g;
        logic [3:0] a;
        logic [15:0] d;
        logic s;
        int lat;
        int al;
        applyReset();
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        words[2] = 16'h1234;
        packWords();
        req = 4'b0100;
        waitGrant(g, lat);
        checks++; if (g !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant: got %b want 0100", g); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL single_grant_latency: got %0d want 1", lat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_at_grant: got %b want 1", busy); end
        req = '0;
        finishTransfer(2, s, d, a, al);
        checks++; if (s !== 1'b1) begin errors++; $display("[TB] FAIL single_start: got %b want 1", s); end
        checks++; if (d !== 16'h1234) begin errors++; $display("[TB] FAIL single_data: got %h want 1234", d); end
        checks++; if (a !== 4'b0100) begin errors++; $display("[TB] FAIL single_ack: got %b want 0100", a); end
        checks++; if (al !== 1) begin errors++; $display("[TB] FAIL single_ack_latency: got %0d want 1", al); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_at_ack: got %b want 1", busy); end
        checks++; if (displayData !== 16'h1234) begin errors++; $display("[TB] FAIL single_data_held: got %h want 1234", displayData); end
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_after_ack: got %b want 0", busy); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_pulse: got %b want 0000", ack); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        logic [3:0] a;
        logic [15:0] d;
        logic s;
        int lat;
        int al;
        int order [5] = '{0, 1, 2, 3, 0};
        applyReset();
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        packWords();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            waitGrant(g, lat);
            checks++; if (g !== (4'b0001 << order[k])) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", k, g, 4'b0001 << order[k]); end
            finishTransfer(2 + (k % 2), s, d, a, al);
            checks++; if (d !== words[order[k]]) begin errors++; $display("[TB] FAIL rr_data%0d: got %h want %h", k, d, words[order[k]]); end
            checks++; if (a !== (4'b0001 << order[k])) begin errors++; $display("[TB] FAIL rr_ack%0d: got %b want %b", k, a, 4'b0001 << order[k]); end
        end
        req = '0;
    endtask

    task automatic test_busy_wait();
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] grantSeen;
        logic [15:0] d;
        logic s;
        int lat;
        int al;
        int n;
        applyReset();
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        packWords();
        req = 4'b0001;
        waitGrant(g, lat);
        checks++; if (g !== 4'b0001) begin errors++; $display("[TB] FAIL bw_grant0: got %b want 0001", g); end
        req = '0;
        @(negedge clock);
        displayDone = 1'b0;
        @(negedge clock);
        @(negedge clock);
        req[1] = 1'b1;
        grantSeen = '0;
        repeat (3) begin
            @(negedge clock);
            grantSeen |= grant;
        end
        checks++; if (grantSeen !== 4'b0000) begin errors++; $display("[TB] FAIL bw_no_grant_while_busy: got %b want 0000", grantSeen); end
        displayDone = 1'b1;
        n = 0;
        a = '0;
        while (a == '0 && n < 40) begin
            @(negedge clock);
            n++;
            a = ack;
        end
        checks++; if (a !== 4'b0001) begin errors++; $display("[TB] FAIL bw_ack0: got %b want 0001", a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bw_busy_at_ack: got %b want 1", busy); end
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bw_busy_gap: got %b want 0", busy); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL bw_grant_gap: got %b want 0000", grant); end
        @(negedge clock);
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL bw_grant1: got %b want 0010", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bw_busy_grant1: got %b want 1", busy); end
        req = '0;
        finishTransfer(2, s, d, a, al);
        checks++; if (a !== 4'b0010) begin errors++; $display("[TB] FAIL bw_ack1: got %b want 0010", a); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] ackSeen;
        logic [15:0] d;
        logic s;
        int lat;
        int al;
        applyReset();
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        packWords();
        req = 4'b1000;
        waitGrant(g, lat);
        checks++; if (g !== 4'b1000) begin errors++; $display("[TB] FAIL rm_grant3: got %b want 1000", g); end
        req = '0;
        @(negedge clock);
        displayDone = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_busy_in_wait: got %b want 1", busy); end
        reset = 1'b1;
        displayDone = 1'b1;
        @(negedge clock);
        checks++; if ({grant, ack, busy, displayStart} !== 10'b0) begin errors++; $display("[TB] FAIL rm_outputs_cleared: got g=%b a=%b b=%b s=%b want all 0", grant, ack, busy, displayStart); end
        checks++; if (displayData !== 16'h0000) begin errors++; $display("[TB] FAIL rm_data_cleared: got %h want 0000", displayData); end
        reset = 1'b0;
        ackSeen = '0;
        repeat (5) begin
            @(negedge clock);
            ackSeen |= ack;
        end
        checks++; if (ackSeen !== 4'b0000) begin errors++; $display("[TB] FAIL rm_no_ack: got %b want 0000", ackSeen); end
        req = 4'b1001;
        waitGrant(g, lat);
        checks++; if (g !== 4'b0001) begin errors++; $display("[TB] FAIL rm_grant_after_reset: got %b want 0001", g); end
        req = 4'b1000;
        finishTransfer(2, s, d, a, al);
        checks++; if (a !== 4'b0001) begin errors++; $display("[TB] FAIL rm_ack0: got %b want 0001", a); end
        waitGrant(g, lat);
        checks++; if (g !== 4'b1000) begin errors++; $display("[TB] FAIL rm_grant3_again: got %b want 1000", g); end
        req = '0;
        finishTransfer(3, s, d, a, al);
        checks++; if (a !== 4'b1000) begin errors++; $display("[TB] FAIL rm_ack3: got %b want 1000", a); end
    endtask

    task automatic test_random();
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] expOneHot;
        logic [15:0] d;
        logic s;
        int lat;
        int al;
        int win;
        applyReset();
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
            packWords();
            req = req | 4'($urandom_range(0, 15));
            if (req == 4'b0000) req = 4'b0001 << $urandom_range(0, 3);
            win = -1;
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && req[(mPtr + k) % 4]) win = (mPtr + k) % 4;
            end
            expOneHot = 4'b0001 << win;
            waitGrant(g, lat);
            checks++; if (g !== expOneHot) begin errors++; $display("[TB] FAIL rand_grant it%0d: got %b want %b (req=%b ptr=%0d)", it, g, expOneHot, req, mPtr); end
            req = req & ~expOneHot;
            finishTransfer($urandom_range(2, 4), s, d, a, al);
            checks++; if (d !== words[win]) begin errors++; $display("[TB] FAIL rand_data it%0d: got %h want %h", it, d, words[win]); end
            checks++; if (a !== expOneHot) begin errors++; $display("[TB] FAIL rand_ack it%0d: got %b want %b", it, a, expOneHot); end
            mPtr = (win + 1) % 4;
        end
        req = '0;
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        logic [3:0] a;
        int lat;
        int n;
        applyReset();
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        packWords();
        req = 4'b0100;
        waitGrant(g, lat);
        checks++; if (g !== 4'b0100) begin errors++; $display("[TB] FAIL to_grant: got %b want 0100", g); end
        req = '0;
        @(negedge clock);
        checks++; if (displayStart !== 1'b1) begin errors++; $display("[TB] FAIL to_start: got %b want 1", displayStart); end
        displayDone = 1'b0;
`ifdef DISPLAY_ARB_TIMEOUT_EN
        n = 0;
        a = '0;
        while (a == '0 && n < 40) begin
            @(negedge clock);
            n++;
            a = ack;
        end
        checks++; if (a !== 4'b0100) begin errors++; $display("[TB] FAIL to_ack: got %b want 0100", a); end
        checks++; if (n !== 8) begin errors++; $display("[TB] FAIL to_ack_delay: got %0d want 8", n); end
        checks++; if (timeoutErr !== 1'b1) begin errors++; $display("[TB] FAIL to_err_set: got %b want 1", timeoutErr); end
        repeat (3) @(negedge clock);
        checks++; if (timeoutErr !== 1'b1) begin errors++; $display("[TB] FAIL to_err_sticky: got %b want 1", timeoutErr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_busy_after_abort: got %b want 0", busy); end
        displayDone = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("[TB] FAIL to_err_cleared: got %b want 0", timeoutErr); end
        reset = 1'b0;
`else
        a = '0;
        n = 0;
        repeat (20) begin
            @(negedge clock);
            a |= ack;
            if (busy !== 1'b1) n++;
        end
        checks++; if (a !== 4'b0000) begin errors++; $display("[TB] FAIL to_no_ack: got %b want 0000", a); end
        checks++; if (n !== 0) begin errors++; $display("[TB] FAIL to_busy_held: busy low %0d cycles, want 0", n); end
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("[TB] FAIL to_err_off: got %b want 0", timeoutErr); end
        applyReset();
`endif
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_wait();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
